// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the register readout serializer.
// The PARITY state exists only when READOUT_PARITY_EN is defined.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef READOUT_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } readout_state_t;

endpackage

// File: rtl/readout_shreg.sv
// Loadable left-shift register with registered MSB tap, zero fill from the LSB.
module readout_shreg #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_data;

    // Load has priority; a full frame of shifts drains the register back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/reg_readout.sv
// Serializes one selected register word MSB first, then pulses done.
// Define READOUT_PARITY_EN to append an even-parity bit to every frame.
module reg_readout
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREGS*WIDTH-1:0]   regs,
    input  logic [$clog2(NREGS)-1:0] addr,
    input  logic                     start,
    output logic                     busy,
    output logic                     sdo,
    output logic                     sdo_valid,
    output logic                     done
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef READOUT_PARITY_EN
    localparam int unsigned FRAME_W = WIDTH + 1;
`else
    localparam int unsigned FRAME_W = WIDTH;
`endif

    readout_state_t   r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_sdo_valid;
    logic             r_done;

    logic [WIDTH-1:0]   w_word;
    logic [FRAME_W-1:0] w_frame;
    logic               w_load;
    logic               w_shift;
    logic               w_msb;

    // Word mux; out-of-range addresses read as zero.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (addr == AW'(i)) begin
                w_word = regs[i*WIDTH +: WIDTH];
            end
        end
    end

    // Parity is known at capture time, so it rides in the shift register as the last bit.
`ifdef READOUT_PARITY_EN
    assign w_frame = {w_word, ^w_word};
    assign w_shift = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
`else
    assign w_frame = w_word;
    assign w_shift = (r_state == ST_SHIFT);
`endif
    assign w_load = (r_state == ST_IDLE) && start;

    readout_shreg #(
        .WIDTH (FRAME_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_frame),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_sdo_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SHIFT;
                        r_cnt       <= CW'(WIDTH - 1);
                        r_busy      <= 1'b1;
                        r_sdo_valid <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
`ifdef READOUT_PARITY_EN
                        r_state     <= ST_PARITY;
`else
                        r_state     <= ST_DONE;
                        r_sdo_valid <= 1'b0;
                        r_done      <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`ifdef READOUT_PARITY_EN
                ST_PARITY: begin
                    r_state     <= ST_DONE;
                    r_sdo_valid <= 1'b0;
                    r_done      <= 1'b1;
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                    r_sdo_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign sdo       = w_msb;
    assign sdo_valid = r_sdo_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_readout.sv
// Directed bench for reg_readout: frame contents, timing, ignored starts, abort and streaming.
module tb_reg_readout;

    localparam int unsigned W = 10;
    localparam int unsigned N = 4;
`ifdef READOUT_PARITY_EN
    localparam int unsigned FW = W + 1;
`else
    localparam int unsigned FW = W;
`endif
    localparam int unsigned PERIOD = FW + 2;

    logic         clk;
    logic         rst;
    logic [N*W-1:0] regs;
    logic [1:0]   addr;
    logic         start;
    logic         busy;
    logic         sdo;
    logic         sdo_valid;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    int            hold_err;
    int            phase_err;
    int            p;
    logic [FW-1:0] f0;
    logic [FW-1:0] f1;

    reg_readout #(
        .WIDTH (W),
        .NREGS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .regs      (regs),
        .addr      (addr),
        .start     (start),
        .busy      (busy),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int unsigned idx, input logic [W-1:0] v);
        regs[idx*W +: W] = v;
    endtask

    // exp_full = {word, even parity}; the default build expects only the word.
    task automatic run_frame(input string tag, input logic [W:0] exp_full,
                             input bit repulse, input bit chg);
        logic [FW-1:0] got;
        int nvalid, ndone, done_cyc, nbusy, leak, first_valid;
        got = '0; nvalid = 0; ndone = 0; done_cyc = 0;
        nbusy = 0; leak = 0; first_valid = 0;
        start = 1'b1;
        for (int c = 1; c <= int'(FW) + 3; c++) begin
            step();
            start = repulse && (c == 3 || c == int'(FW) + 1);
            if (chg && c == 2) set_word(1, 10'h0AA);
            if (c == 1) first_valid = int'(sdo_valid);
            if (sdo_valid) begin
                got = {got[FW-2:0], sdo};
                nvalid++;
            end else if (sdo) begin
                leak++;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (busy) nbusy++;
        end
        start = 1'b0;
        chk({tag, "_frame"},    32'(got),         32'(exp_full[W -: FW]));
        chk({tag, "_nvalid"},   32'(nvalid),      FW);
        chk({tag, "_ndone"},    32'(ndone),       1);
        chk({tag, "_done_cyc"}, 32'(done_cyc),    FW + 1);
        chk({tag, "_nbusy"},    32'(nbusy),       FW + 1);
        chk({tag, "_sdo_leak"}, 32'(leak),        0);
        chk({tag, "_first"},    32'(first_valid), 1);
    endtask

    initial begin
        rst   = 1'b1;
        regs  = '0;
        addr  = '0;
        start = 1'b0;
        #1 rst = 1'b0;
        #11;
        chk("rst_busy",  32'(busy),      0);
        chk("rst_sdo",   32'(sdo),       0);
        chk("rst_valid", 32'(sdo_valid), 0);
        chk("rst_done",  32'(done),      0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("idle_busy", 32'(busy), 0);

        // 10'h2A5 -> 1,0,1,0,1,0,0,1,0,1, parity 1
        set_word(2, 10'h2A5);
        addr = 2'd2;
        run_frame("t_basic", {10'h2A5, 1'b1}, 1'b0, 1'b0);

        set_word(0, 10'h3FF);
        addr = 2'd0;
        run_frame("t_ones", {10'h3FF, 1'b0}, 1'b0, 1'b0);
        set_word(0, 10'h001);
        run_frame("t_lsb", {10'h001, 1'b1}, 1'b0, 1'b0);

        // Starts on cycle 3 and in the done cycle must be dropped.
        addr = 2'd2;
        run_frame("t_repulse", {10'h2A5, 1'b1}, 1'b1, 1'b0);

        // word1 rewritten to 10'h0AA mid-frame; the captured 10'h155 must survive.
        set_word(1, 10'h155);
        addr = 2'd1;
        run_frame("t_hold", {10'h155, 1'b1}, 1'b0, 1'b1);

        // Abort at cycle 5, where the frame shows bit 5 of 10'h2A5 (a one).
        set_word(3, 10'h2A5);
        addr  = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("abort_pre_sdo", 32'(sdo), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy",  32'(busy),      0);
        chk("abort_sdo",   32'(sdo),       0);
        chk("abort_valid", 32'(sdo_valid), 0);
        chk("abort_done",  32'(done),      0);
        hold_err = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done || busy || sdo_valid) hold_err++;
        end
        rst = 1'b1;
        step();
        if (done || busy || sdo_valid) hold_err++;
        chk("abort_quiet", 32'(hold_err), 0);
        set_word(3, 10'h001);
        run_frame("t_after_rst", {10'h001, 1'b1}, 1'b0, 1'b0);

        // Start held high: frame, done, one idle cycle, repeat.
        addr      = 2'd2;
        f0        = '0;
        f1        = '0;
        phase_err = 0;
        start     = 1'b1;
        for (int c = 1; c <= 2 * int'(PERIOD); c++) begin
            step();
            p = (c - 1) % int'(PERIOD);
            if (sdo_valid !== (p < int'(FW)))  phase_err++;
            if (done      !== (p == int'(FW))) phase_err++;
            if (busy      !== (p <= int'(FW))) phase_err++;
            if (sdo_valid) begin
                if (c <= int'(PERIOD)) f0 = {f0[FW-2:0], sdo};
                else                   f1 = {f1[FW-2:0], sdo};
            end
        end
        start = 1'b0;
        chk("stream_phase",  32'(phase_err), 0);
        chk("stream_frame0", 32'(f0), 32'(FW == W + 1 ? 11'h54B : 11'h2A5));
        chk("stream_frame1", 32'(f1), 32'(FW == W + 1 ? 11'h54B : 11'h2A5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
